// File: rtl/buma_pkg.sv
// Shared definitions for the two's-complement to sign-magnitude decoder.
//   state_e        : decoder FSM states (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH  : default operand width, sign bit included
//   minneg_value() : most-negative operand pattern (1 followed by zeros)
package buma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

  function automatic logic [63:0] minneg_value(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/buma_serial_cell.sv
// One-bit serial negation cell: copy bits through the first 1, invert after it.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of seen_one (start of a new operand)
//   en         : advance seen_one with the current bit
//   b          : current LSB of the operand
//   sign       : operand is negative (enables the inversion)
//   bit_out    : decoded output bit for this cycle
module buma_serial_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic b,
  input  logic sign,
  output logic bit_out
);

  logic seen_one_q;
  logic seen_one_d;

  always_comb begin
    seen_one_d = seen_one_q;
    if (clr) begin
      seen_one_d = 1'b0;
    end else if (en) begin
      seen_one_d = seen_one_q | b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_one_q <= 1'b0;
    end else begin
      seen_one_q <= seen_one_d;
    end
  end

  assign bit_out = b ^ (sign & seen_one_q);

endmodule

// File: rtl/buma_decode.sv
// Bit-serial two's-complement to sign-magnitude decoder, LSB first.
//   in_valid/in_ready/in_data      : operand handshake (WIDTH-bit two's complement)
//   out_valid/out_ready            : result handshake
//   out_sign, out_mag              : sign and unsigned magnitude of the operand
//   out_minneg                     : operand was the most-negative value
// Latency is WIDTH cycles from accept to out_valid; one operand per WIDTH+2
// cycles with out_ready held high.
module buma_decode
  import buma_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_minneg
);

  localparam int unsigned     CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST   = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MINNEG = WIDTH'(minneg_value(WIDTH));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             minneg_pend_q, minneg_pend_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sign_q, out_sign_d;
  logic [WIDTH-1:0] out_mag_q, out_mag_d;
  logic             out_minneg_q, out_minneg_d;
  logic             cell_clr, cell_en, bit_out;

  buma_serial_cell u_cell (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cell_clr),
    .en      (cell_en),
    .b       (shreg_q[0]),
    .sign    (sign_q),
    .bit_out (bit_out)
  );

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    res_d         = res_q;
    cnt_d         = cnt_q;
    sign_d        = sign_q;
    minneg_pend_d = minneg_pend_q;
    out_valid_d   = out_valid_q;
    out_sign_d    = out_sign_q;
    out_mag_d     = out_mag_q;
    out_minneg_d  = out_minneg_q;
    cell_clr      = 1'b0;
    cell_en       = 1'b0;

    case (state_q)
      IDLE: begin
        // in_data is only sampled on an accept edge, so X while idle never reaches state.
        if (in_valid && in_ready_q) begin
          shreg_d       = in_data;
          sign_d        = in_data[WIDTH-1];
          minneg_pend_d = (in_data == MINNEG);
          cnt_d         = '0;
          cell_clr      = 1'b1;
          state_d       = SHIFT;
        end
      end
      SHIFT: begin
        cell_en = 1'b1;
        shreg_d = shreg_q >> 1;
        res_d   = {bit_out, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          out_mag_d    = {bit_out, res_q[WIDTH-1:1]};
          out_sign_d   = sign_q;
          out_minneg_d = minneg_pend_q;
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered so that in_ready stays low throughout reset and rises on the first edge after it.
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      res_q         <= '0;
      cnt_q         <= '0;
      sign_q        <= 1'b0;
      minneg_pend_q <= 1'b0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_sign_q    <= 1'b0;
      out_mag_q     <= '0;
      out_minneg_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      res_q         <= res_d;
      cnt_q         <= cnt_d;
      sign_q        <= sign_d;
      minneg_pend_q <= minneg_pend_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_sign_q    <= out_sign_d;
      out_mag_q     <= out_mag_d;
      out_minneg_q  <= out_minneg_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_sign   = out_sign_q;
  assign out_mag    = out_mag_q;
  assign out_minneg = out_minneg_q;

endmodule

// File: tb/tb_buma_decode.sv
// Self-checking bench for buma_decode (WIDTH=4): directed cases plus random
// operands compared against an arithmetic reference model.
module tb_buma_decode;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [W-1:0] out_mag;
  logic         out_minneg;

  int n_checks;
  int n_fail;

  buma_decode #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_mag    (out_mag),
    .out_minneg (out_minneg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: interpret x as a signed integer and take its absolute value.
  function automatic int ref_sign(input int x);
    return (x >= (1 << (W - 1))) ? 1 : 0;
  endfunction

  function automatic int ref_mag(input int x);
    int v;
    v = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ref_minneg(input int x);
    return (x == (1 << (W - 1))) ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("ready_timeout", {31'd0, (n >= 50)}, 0);
  endtask

  // One complete transaction: accept x, check latency, hold out_ready low
  // for 'hold' cycles while checking stability, then drain.
  task automatic do_op(input int x, input int hold);
    int k;
    out_ready = (hold == 0);
    wait_ready();
    in_valid = 1'b1;
    in_data  = W'(x);
    step();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    check("busy_rdy", {31'd0, in_ready}, 0);
    k = 0;
    while (k < 20) begin
      step();
      in_data = W'($urandom);
      k++;
      if (out_valid) break;
    end
    check("latency", k, W);
    check("sign", {31'd0, out_sign}, ref_sign(x));
    check("mag", {28'd0, out_mag}, ref_mag(x));
    check("minneg", {31'd0, out_minneg}, ref_minneg(x));
    for (int h = 0; h < hold; h++) begin
      step();
      check("bp_valid", {31'd0, out_valid}, 1);
      check("bp_mag", {28'd0, out_mag}, ref_mag(x));
      check("bp_sign", {31'd0, out_sign}, ref_sign(x));
      if (h == hold - 1) out_ready = 1'b1;
    end
    step();
    check("drop_valid", {31'd0, out_valid}, 0);
    check("drop_rdy", {31'd0, in_ready}, 1);
    check("hold_mag", {28'd0, out_mag}, ref_mag(x));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    #12;
    check("rst_rdy", {31'd0, in_ready}, 0);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_mag", {28'd0, out_mag}, 0);
    check("rst_sign", {31'd0, out_sign}, 0);
    check("rst_minneg", {31'd0, out_minneg}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_rdy", {31'd0, in_ready}, 1);

    do_op(13, 0);   // -3
    do_op(5, 0);
    do_op(8, 0);    // most negative
    do_op(10, 5);   // -6 with backpressure

    // Back-to-back 0 then -1 with in_valid held throughout.
    out_ready = 1'b1;
    wait_ready();
    in_valid = 1'b1;
    in_data  = 4'h0;
    step();
    in_data = 4'hF;
    for (int t = 0; t < 5; t++) begin
      check("b2b_rdy_low", {31'd0, in_ready}, 0);
      if (t == 4) begin
        check("b2b1_valid", {31'd0, out_valid}, 1);
        check("b2b1_sign", {31'd0, out_sign}, 0);
        check("b2b1_mag", {28'd0, out_mag}, 0);
      end
      step();
    end
    check("b2b_rdy_6", {31'd0, in_ready}, 1);
    step();
    in_valid = 1'b0;
    for (int t = 0; t < W; t++) step();
    check("b2b2_valid", {31'd0, out_valid}, 1);
    check("b2b2_sign", {31'd0, out_sign}, 1);
    check("b2b2_mag", {28'd0, out_mag}, 1);
    step();
    check("b2b2_drop", {31'd0, out_valid}, 0);

    // Async reset during the second SHIFT cycle of -3 (prior result is nonzero).
    wait_ready();
    in_valid = 1'b1;
    in_data  = 4'hD;
    step();
    in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 0);
    check("mid_rst_mag", {28'd0, out_mag}, 0);
    check("mid_rst_sign", {31'd0, out_sign}, 0);
    check("mid_rst_rdy", {31'd0, in_ready}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      step();
      check("no_stale", {31'd0, out_valid}, 0);
    end
    do_op(2, 0);

    for (int i = 0; i < 40; i++) begin
      do_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buma_decode.md
Name: buma_decode

Overview:
- Converts a WIDTH-bit two's-complement operand (補码) back into sign-magnitude form (sign bit plus unsigned magnitude).
- It is the decode-side counterpart of the team's combinational complement/negation encoder.
- Bit-serial, LSB-first datapath with valid/ready handshakes on both sides.
- Sits between the complement arithmetic unit and display/compare logic that consumes sign-magnitude values.

Parameters:
- WIDTH, 4: operand width in bits, including the sign bit; must be >= 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  WIDTH  two's-complement operand.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- out_sign  out  1  sign of the result; 1 means negative.
- out_mag  out  WIDTH  unsigned magnitude.
- out_minneg  out  1  operand was the most-negative value, whose magnitude cannot fit in a (WIDTH-1)-bit sign-magnitude field.

Behaviour:
- Reset: rst_n low clears everything immediately, regardless of clk.
  - state=IDLE; in_ready=0 while rst_n is low.
  - out_valid=0, out_sign=0, out_mag=0, out_minneg=0.
  - Internal shift register, bit counter and seen_one flag cleared.
  - On the first edge after release, state is IDLE and in_ready=1.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1:
    - Load in_data into the shift register.
    - Latch sign = in_data[WIDTH-1].
    - out_minneg_next = (in_data == 1 followed by WIDTH-1 zeros).
    - Clear the counter and seen_one; go to SHIFT.
  - in_ready=0 in every other state.
- SHIFT: one bit per cycle, LSB first, for exactly WIDTH cycles.
  - b is the current LSB of the shift register.
  - sign=0: output bit = b (copy).
  - sign=1: output bit = b XOR seen_one; then seen_one |= b. This is the copy-through-first-1-then-invert rule and equals -x mod 2^WIDTH.
  - Output bits shift into a result register MSB-in, so after WIDTH shifts the result is aligned.
  - When the counter reaches WIDTH-1, that edge loads out_mag, out_sign and out_minneg, sets out_valid=1, and goes to DONE.
- DONE:
  - out_valid=1; outputs held stable, with no glitches, while out_ready=0.
  - On an edge with out_ready=1: out_valid=0, go to IDLE. Output data registers keep their last value.
- Latency: out_valid rises exactly WIDTH cycles after the input-accept edge, independent of the value.
- Throughput: one operand per WIDTH+2 cycles when out_ready is held high. Inputs and outputs never overlap.
- Arithmetic rules:
  - out_mag = |x| as unsigned WIDTH bits.
  - The most-negative value gives out_mag = 2^(WIDTH-1), out_sign=1, out_minneg=1.
  - Zero gives sign 0, mag 0.
  - Positive values pass through unchanged with sign 0.
- Boundary conditions:
  - in_valid held high while busy is ignored; the operand is not consumed until in_ready.
  - in_data changes during SHIFT have no effect.
  - out_ready high outside DONE has no effect.
  - Reset asserted mid-SHIFT or in DONE discards the operation with no partial output.
  - X on in_data while in_valid=0 must not propagate into state.

Decomposition:
- Shared package (buma_pkg):
  - State encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default WIDTH.
  - MINNEG constant function/localparam, computed from WIDTH.
- One natural sub-module: buma_serial_cell.
  - Contains the seen_one flop (async active-low reset, synchronous clear input, enable).
  - Combinational output bit = b XOR (sign AND seen_one).
  - The top instantiates it once.

Test Plan:
- WIDTH=4, in_data=4'b1101 (-3), out_ready=1:
  - out_valid rises 4 cycles after accept.
  - out_sign=1, out_mag=4'd3, out_minneg=0.
- in_data=4'd5:
  - out_sign=0, out_mag=4'd5, out_minneg=0; same 4-cycle latency.
- in_data=4'b1000 (-8):
  - out_sign=1, out_mag=4'd8, out_minneg=1.
- in_data=4'b0000 then 4'b1111 back-to-back with in_valid held:
  - First result: sign 0, mag 0. Second result: sign 1, mag 1.
  - Second accept occurs exactly 6 cycles after the first; in_ready=0 in between.
- Backpressure: in_data=4'b1010 (-6), out_ready=0 for 5 cycles after out_valid:
  - out_sign=1, out_mag=6 held constant.
  - Drop occurs on the edge where out_ready=1; in_ready=1 the next cycle.
- Assert rst_n=0 asynchronously during the 2nd SHIFT cycle of -3:
  - All outputs 0 immediately.
  - After release, no stale result appears; a fresh +2 gives sign 0, mag 2.
